// File: rtl/scope_level_regs.sv
// scope_level_regs: double-buffered Avalon-MM register bank for the analog
// control levels. The CPU writes shadow registers, and the shadow set is copied
// to the active outputs in one atomic commit. The commit can be gated by an
// acquisition-idle sync strobe.
module scope_level_regs #(
    parameter int                 DATA_W    = 8,
    parameter int                 NUM_CH    = 4,
    parameter logic [DATA_W-1:0]  RESET_VAL = '0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [3:0]               address,
    input  logic                     chipselect,
    input  logic                     write_n,
    input  logic [31:0]              writedata,
    output logic [31:0]              readdata,
    input  logic                     sync_in,
    output logic [NUM_CH*DATA_W-1:0] out_port,
    output logic                     irq
);

    localparam logic [3:0] ADDR_CTRL   = 4'd14;
    localparam logic [3:0] ADDR_STATUS = 4'd15;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic              done_q, done_d;
    logic [2:0]        ctrl_q, ctrl_d;   // {IRQ_EN, SYNC_EN, IMM}
    logic [DATA_W-1:0] shadow_q [NUM_CH];
    logic [DATA_W-1:0] shadow_d [NUM_CH];
    logic [DATA_W-1:0] active_q [NUM_CH];
    logic [DATA_W-1:0] active_d [NUM_CH];

    logic wr_en;
    logic ctrl_wr;
    logic status_wr;
    logic commit;
    logic pending;
    logic unused_wdata;

    assign wr_en     = chipselect & ~write_n;
    assign ctrl_wr   = wr_en && (address == ADDR_CTRL);
    assign status_wr = wr_en && (address == ADDR_STATUS);
    assign pending   = (state_q == PEND);
    assign irq       = done_q & ctrl_q[2];
    // Writedata bits above the channel width carry no information for this block.
    assign unused_wdata = ^writedata;

    // Commit FSM next state and DONE flag; a commit sets DONE and wins over a clear.
    always_comb begin
        state_d = state_q;
        done_d  = done_q;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (status_wr && writedata[0]) begin
                    state_d = PEND;
                end
            end
            PEND: begin
                if (!ctrl_q[1] || sync_in) begin
                    state_d = IDLE;
                    commit  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (commit) begin
            done_d = 1'b1;
        end else if (status_wr && writedata[1]) begin
            done_d = 1'b0;
        end
    end

    // Control register next state.
    assign ctrl_d = ctrl_wr ? writedata[2:0] : ctrl_q;

    // Shadow/active next state: commit copies pre-write shadows; an immediate-mode write overrides.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            shadow_d[i] = shadow_q[i];
            active_d[i] = active_q[i];
            if (commit) begin
                active_d[i] = shadow_q[i];
            end
            if (wr_en && (address == 4'(i))) begin
                shadow_d[i] = writedata[DATA_W-1:0];
                if (ctrl_q[0]) begin
                    active_d[i] = writedata[DATA_W-1:0];
                end
            end
        end
    end

    // State registers; an asynchronous reset discards any pending commit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            ctrl_q  <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= RESET_VAL;
                active_q[i] <= RESET_VAL;
            end
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            ctrl_q  <= ctrl_d;
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= shadow_d[i];
                active_q[i] <= active_d[i];
            end
        end
    end

    // Combinational read mux; unmapped addresses read as zero.
    always_comb begin
        readdata = '0;
        if (address == ADDR_CTRL) begin
            readdata = {29'b0, ctrl_q};
        end else if (address == ADDR_STATUS) begin
            readdata = {30'b0, done_q, pending};
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (address == 4'(i)) begin
                    readdata = 32'(shadow_q[i]);
                end
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_out
            assign out_port[g*DATA_W +: DATA_W] = active_q[g];
        end
    endgenerate

endmodule

// File: tb/tb_scope_level_regs.sv
// Directed bench for scope_level_regs with DATA_W=8, NUM_CH=4, RESET_VAL=8'h80.
module tb_scope_level_regs;

    logic        clk;
    logic        reset_n;
    logic [3:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        sync_in;
    logic [31:0] out_port;
    logic        irq;

    int tests;
    int failed;

    scope_level_regs #(
        .DATA_W    (8),
        .NUM_CH    (4),
        .RESET_VAL (8'h80)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .sync_in    (sync_in),
        .out_port   (out_port),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_rd(input string tag, input logic [3:0] a, input logic [31:0] exp);
        address = a;
        #1;
        check(tag, readdata, exp);
    endtask

    // One write cycle; returns 1 time unit after the capturing edge.
    task automatic bus_write(input logic [3:0] a, input logic [31:0] d, input logic s);
        @(negedge clk);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        sync_in    = s;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        sync_in    = 1'b0;
    endtask

    task automatic sync_pulse();
        @(negedge clk);
        sync_in = 1'b1;
        @(posedge clk);
        #1;
        sync_in = 1'b0;
    endtask

    initial begin
        tests      = 0;
        failed     = 0;
        reset_n    = 1'b0;
        address    = 4'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        sync_in    = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_port", out_port, 32'h80808080);
        check("rst_irq", {31'b0, irq}, 32'd0);
        check_rd("rst_status", 4'd15, 32'd0);
        check_rd("rst_ctrl", 4'd14, 32'd0);
        check_rd("rst_ch2", 4'd2, 32'h80);
        check_rd("unmapped_rd", 4'd7, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Buffered commit, no sync gating
        bus_write(4'd2, 32'h5A, 1'b0);
        check_rd("buf_ch2_shadow", 4'd2, 32'h5A);
        check("buf_out_unchanged", out_port, 32'h80808080);
        bus_write(4'd7, 32'hFF, 1'b0);
        check_rd("unmapped_wr_ignored", 4'd7, 32'd0);
        bus_write(4'd15, 32'h1, 1'b0);
        check_rd("buf_pending", 4'd15, 32'h1);
        check("buf_out_pre_commit", out_port, 32'h80808080);
        @(posedge clk);
        #1;
        check("buf_out_committed", out_port, 32'h805A8080);
        check_rd("buf_status_done", 4'd15, 32'h2);
        check("buf_irq_masked", {31'b0, irq}, 32'd0);
        bus_write(4'd15, 32'h2, 1'b0);
        check_rd("done_cleared", 4'd15, 32'd0);

        // Sync-gated commit with interrupt
        bus_write(4'd14, 32'h6, 1'b0);
        check_rd("ctrl_rd", 4'd14, 32'h6);
        bus_write(4'd3, 32'h33, 1'b0);
        bus_write(4'd15, 32'h1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("sync_wait_out", out_port, 32'h805A8080);
            check_rd("sync_wait_pending", 4'd15, 32'h1);
        end
        sync_pulse();
        check("sync_out_committed", out_port, 32'h335A8080);
        check_rd("sync_status", 4'd15, 32'h2);
        check("sync_irq_set", {31'b0, irq}, 32'd1);
        bus_write(4'd15, 32'h2, 1'b0);
        check("sync_irq_cleared", {31'b0, irq}, 32'd0);

        // Request with sync_in high in the same cycle: that sync is ignored
        bus_write(4'd1, 32'h22, 1'b0);
        bus_write(4'd15, 32'h1, 1'b1);
        check_rd("req_sync_ignored", 4'd15, 32'h1);
        @(posedge clk);
        #1;
        check("req_sync_still_pend_out", out_port, 32'h335A8080);
        // Channel write on the commit edge: active takes the old shadow
        bus_write(4'd1, 32'h11, 1'b1);
        check("simul_active_old", out_port, 32'h335A2280);
        check_rd("simul_shadow_new", 4'd1, 32'h11);
        check_rd("simul_status_done", 4'd15, 32'h2);
        check("simul_irq", {31'b0, irq}, 32'd1);
        // Request and DONE clear in one write: both take effect
        bus_write(4'd15, 32'h3, 1'b0);
        check_rd("req_and_clear", 4'd15, 32'h1);
        check("req_and_clear_irq", {31'b0, irq}, 32'd0);
        // DONE clear on the commit edge: set wins
        bus_write(4'd15, 32'h2, 1'b1);
        check("second_commit_out", out_port, 32'h335A1180);
        check_rd("set_wins_clear", 4'd15, 32'h2);
        // Masking IRQ_EN hides irq but keeps DONE
        bus_write(4'd14, 32'h2, 1'b0);
        check("irq_masked", {31'b0, irq}, 32'd0);
        check_rd("done_kept_masked", 4'd15, 32'h2);
        bus_write(4'd15, 32'h2, 1'b0);

        // Immediate mode
        bus_write(4'd14, 32'h1, 1'b0);
        bus_write(4'd0, 32'hC3, 1'b0);
        check("imm_out", out_port, 32'h335A11C3);
        check_rd("imm_done_clear", 4'd15, 32'd0);

        // Reset while pending
        bus_write(4'd14, 32'h2, 1'b0);
        bus_write(4'd0, 32'h44, 1'b0);
        bus_write(4'd15, 32'h1, 1'b0);
        check_rd("pend_before_rst", 4'd15, 32'h1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_rd("rst_mid_status", 4'd15, 32'd0);
        check("rst_mid_out", out_port, 32'h80808080);
        check_rd("rst_mid_ch0", 4'd0, 32'h80);
        @(negedge clk);
        reset_n = 1'b1;
        sync_pulse();
        @(posedge clk);
        #1;
        check("rst_no_commit_out", out_port, 32'h80808080);
        check_rd("rst_no_commit_status", 4'd15, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/scope_level_regs.md
# scope_level_regs

Parametrised, double-buffered Avalon-MM output register bank for the scope's analog control levels: trigger level, trigger hysteresis, channel offsets and similar values. It holds NUM_CH channels of DATA_W bits each. Values are written into shadow registers by the CPU. They are then transferred to the active outputs together, in one atomic commit. A commit can be gated by an acquisition-idle sync pulse, so the trigger logic never sees a half-updated set of levels. The block sits on the system Avalon bus beside the other PIO peripherals, and its out_port drives the trigger/acquisition logic directly.

## Interface
- DATA_W, 8, width of each channel register (1..32)
- NUM_CH, 4, number of channels (1..14)
- RESET_VAL, 0, reset value of every shadow and active register (DATA_W bits)

- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- address  in  4  word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  combinational read data; unused bits 0
- sync_in  in  1  commit-enable strobe, synchronous to clk (acquisition idle)
- out_port  out  NUM_CH*DATA_W  active values; channel i occupies bits [i*DATA_W +: DATA_W]
- irq  out  1  commit-done interrupt, level

## Operation
- Address map:
  - 0..NUM_CH-1: shadow register for channel i.
  - 14: CTRL.
  - 15: STATUS.
  - Any other address: reads 0, writes ignored.
- A write is a cycle with chipselect=1 and write_n=0. There are no wait states.
- Channel write: shadow[i] <= writedata[DATA_W-1:0].
  - If CTRL.IMM=1, active[i] is also loaded from writedata in the same edge.
- Channel read returns shadow[i], zero-extended.
- CTRL register (read/write):
  - bit0 IMM: 1 = immediate mode; 0 = buffered mode.
  - bit1 SYNC_EN: 1 = a commit waits for sync_in.
  - bit2 IRQ_EN: interrupt enable.
  - CTRL resets to 0, i.e. buffered mode, no sync gating, irq disabled.
- STATUS read:
  - bit0 PENDING.
  - bit1 DONE.
- STATUS write:
  - writedata[0]=1 requests a commit.
  - writedata[1]=1 clears DONE (write-1-to-clear).
- Commit state machine has two states, IDLE and PEND. PENDING=1 exactly in state PEND.
  - IDLE -> PEND on a commit request.
  - PEND -> IDLE when SYNC_EN=0 or sync_in=1. On that edge:
    - every active[i] <= shadow[i];
    - DONE <= 1.
  - A commit request while in PEND has no effect.
- irq = DONE & IRQ_EN. Clearing IRQ_EN masks irq without clearing DONE.

## Timing
- Reset (asynchronous):
  - all shadow and active registers = RESET_VAL, so out_port = RESET_VAL replicated;
  - CTRL = 0, state IDLE, DONE = 0, irq = 0;
  - readdata reflects the reset register values.
- Immediate-mode write: out_port changes on the same clock edge that captures the write (1-cycle latency from write cycle to output).
- Buffered commit with SYNC_EN=0:
  - request written at edge T -> PEND at T;
  - commit at edge T+1; out_port and DONE update at T+1.
- Buffered commit with SYNC_EN=1:
  - the commit occurs at the first edge after T at which sync_in=1;
  - sync_in=1 during the request-write cycle itself is ignored.
- Simultaneous events:
  - Channel write in the same cycle as the commit edge: active takes the pre-write shadow value. The new shadow value waits for the next commit, unless IMM=1, in which case the write's active update takes priority for that channel.
  - DONE set (commit) and DONE clear in the same cycle: set wins.
  - Request and DONE-clear in one STATUS write: both take effect.
- Changing SYNC_EN or IMM while in PEND: takes effect from the next cycle. Clearing SYNC_EN while in PEND causes a commit on the next edge.
- Reset asserted mid-PEND: the pending commit is discarded and all outputs return to their reset values.
- Read data is combinational from the current register state, with no read latency.

## Test plan
- Reset with DATA_W=8, NUM_CH=4, RESET_VAL=8'h80 -> out_port=32'h80808080, irq=0, STATUS=0, CTRL=0.
- Buffered mode, SYNC_EN=0: write ch2=8'h5A, read ch2 -> 0x5A while out_port is unchanged; write STATUS=1 -> PENDING=1 for one cycle, then out_port[23:16]=8'h5A, STATUS=2.
- SYNC_EN=1, IRQ_EN=1: request a commit, hold sync_in=0 for 10 cycles -> PENDING=1 and out_port unchanged throughout; pulse sync_in -> commit on that edge and irq=1; write STATUS=2 -> irq=0.
- Immediate mode (CTRL=1): write ch0=8'hC3 -> out_port[7:0]=8'hC3 on the next edge; DONE stays 0.
- Write ch1=8'h11 in the same cycle as the sync-gated commit edge, with shadow ch1 previously 8'h22 -> active ch1=8'h22, shadow reads 8'h11; a second commit -> 8'h11.
- Assert reset_n while in PEND -> PENDING=0 and out_port=RESET_VAL immediately; a later sync_in pulse causes no commit.
